// File: rtl/fastserial_tx_arbiter.sv
// fastserial_tx_arbiter
// Shares one FTDI fast-serial byte transmitter between NUM_REQ packet streams.
// Grants are round-robin and held for a whole packet (until the `last` byte).
// Each byte is handed over with a one-cycle write strobe. The arbiter then
// waits for busy to rise, bounded by BUSY_WAIT cycles, and then waits for
// busy to fall.
// Optional feature: define FSARB_GAP_TIMEOUT_EN to drop a grant whose owner
// goes silent mid-packet for GAP_TIMEOUT cycles; this adds o_abort_count.
module fastserial_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int BUSY_WAIT   = 4,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_write,
    input  logic                 i_tx_busy,
    output logic                 o_nobusy_err
`ifdef FSARB_GAP_TIMEOUT_EN
    ,
    output logic [7:0]           o_abort_count
`endif
);

    localparam int PTR_W  = (NUM_REQ > 2) ? 2 : 1;
    localparam int BCNT_W = $clog2(BUSY_WAIT + 1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

    // Elaboration-time guard on the legal parameter ranges
    if (NUM_REQ < 2 || NUM_REQ > 4 || BUSY_WAIT < 1 || GAP_TIMEOUT < 1) begin : g_bad_params
        $error("fastserial_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_ACK,
        ST_DONE
    } state_t;

    state_t              state_q,    state_d;
    logic [NUM_REQ-1:0]  grant_q,    grant_d;
    logic [PTR_W-1:0]    gidx_q,     gidx_d;
    logic [PTR_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_write_q, tx_write_d;
    logic                last_q,     last_d;
    logic                err_q,      err_d;
    logic [BCNT_W-1:0]   bcnt_q,     bcnt_d;

`ifdef FSARB_GAP_TIMEOUT_EN
    localparam int GCNT_W = $clog2(GAP_TIMEOUT + 1);
    logic [GCNT_W-1:0]   gcnt_q,     gcnt_d;
    logic [7:0]          abort_q,    abort_d;
`endif

    logic [7:0]          req_byte [NUM_REQ];
    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic                xfer;

    // Split the packed data bus into one byte per requester
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_byte[k] = i_req_data[8*k +: 8];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr, with wrap
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && i_req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // Pointer value that gives the next requester priority once the owner is done
    assign next_ptr = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;

    // Ready only to the owner, and only while the transmitter is free
    assign xfer        = (state_q == ST_SEND) && !i_tx_busy && i_req_valid[gidx_q];
    assign o_req_ready = ((state_q == ST_SEND) && !i_tx_busy) ? grant_q : '0;

    // Next-state logic for the arbitration / handshake sequencer
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_write_d = 1'b0;
        last_d     = last_q;
        err_d      = err_q;
        bcnt_d     = bcnt_q;
`ifdef FSARB_GAP_TIMEOUT_EN
        gcnt_d     = gcnt_q;
        abort_d    = abort_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = GRANT_ONE << pick_idx;
                    gidx_d  = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    tx_data_d  = req_byte[gidx_q];
                    last_d     = i_req_last[gidx_q];
                    tx_write_d = 1'b1;
                    bcnt_d     = '0;
                    state_d    = ST_ACK;
`ifdef FSARB_GAP_TIMEOUT_EN
                    gcnt_d     = '0;
`endif
                end
`ifdef FSARB_GAP_TIMEOUT_EN
                else if (!i_req_valid[gidx_q]) begin
                    // Owner silent mid-packet: abandon the packet after GAP_TIMEOUT idle cycles
                    if (int'(gcnt_q) >= GAP_TIMEOUT - 1) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        gcnt_d   = '0;
                        state_d  = ST_IDLE;
                        if (abort_q != 8'hFF) begin
                            abort_d = abort_q + 8'd1;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_ACK: begin
                if (i_tx_busy) begin
                    state_d = ST_DONE;
                end else if (int'(bcnt_q) >= BUSY_WAIT - 1) begin
                    // Transmitter never acknowledged; flag it and carry on
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!i_tx_busy) begin
                    if (last_q) begin
                        rr_ptr_d = next_ptr;
                        grant_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_write_q <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            bcnt_q     <= '0;
`ifdef FSARB_GAP_TIMEOUT_EN
            gcnt_q     <= '0;
            abort_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_write_q <= tx_write_d;
            last_q     <= last_d;
            err_q      <= err_d;
            bcnt_q     <= bcnt_d;
`ifdef FSARB_GAP_TIMEOUT_EN
            gcnt_q     <= gcnt_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign o_grant      = grant_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_write   = tx_write_q;
    assign o_nobusy_err = err_q;
`ifdef FSARB_GAP_TIMEOUT_EN
    assign o_abort_count = abort_q;
`endif

endmodule

// File: tb/tb_fastserial_tx_arbiter.sv
// Bench for fastserial_tx_arbiter: directed scenarios plus randomized packet
// traffic, compared against a packet-level round-robin reference model.
// Build with FSARB_GAP_TIMEOUT_EN defined to include the gap-timeout scenario.
module tb_fastserial_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_busy = 1'b0;
    logic        nobusy_err;
`ifdef FSARB_GAP_TIMEOUT_EN
    logic [7:0]  abort_count;
`endif

    fastserial_tx_arbiter #(
        .NUM_REQ    (2),
        .BUSY_WAIT  (4),
        .GAP_TIMEOUT(16)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .i_req_last   (req_last),
        .o_req_ready  (req_ready),
        .o_grant      (grant),
        .o_tx_data    (tx_data),
        .o_tx_write   (tx_write),
        .i_tx_busy    (tx_busy),
        .o_nobusy_err (nobusy_err)
`ifdef FSARB_GAP_TIMEOUT_EN
        ,
        .o_abort_count(abort_count)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [8:0] pq0[$];          // requester 0 bytes: {last, data}
    logic [8:0] pq1[$];          // requester 1 bytes: {last, data}
    logic [7:0] got[$];          // bytes seen on the write strobe
    logic [7:0] exp_q[$];        // expected transmitter byte stream
    int         wr_cyc[$];       // cycle index of each write strobe
    int         busy_start = 0;
    int         busy_end = 0;
    int         rise_dly = 2;
    int         hold_len = 10;
    bit         rand_busy = 0;
    bit         no_busy = 0;
    bit         gaps_en = 0;
    bit         inpkt0 = 0;
    bit         inpkt1 = 0;
    bit         xfer0 = 0;
    bit         xfer1 = 0;
    logic       prev_write = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bench();
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_busy = 1'b0;
        pq0.delete();
        pq1.delete();
        got.delete();
        wr_cyc.delete();
        busy_start = 0;
        busy_end = 0;
        inpkt0 = 0;
        inpkt1 = 0;
        xfer0 = 0;
        xfer1 = 0;
        prev_write = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        clear_bench();
        #1;
        check({tag, "_rst_grant"}, 32'(grant), 32'd0);
        check({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rst_data"}, 32'(tx_data), 32'd0);
        check({tag, "_rst_write"}, 32'(tx_write), 32'd0);
        check({tag, "_rst_err"}, 32'(nobusy_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add_pkt(input int r, input int len, input logic [7:0] base, input bit rnd);
        logic [8:0] e;
        for (int i = 0; i < len; i++) begin
            e[7:0] = rnd ? 8'($urandom) : base + 8'(i);
            e[8] = (i == len - 1);
            if (r == 0) pq0.push_back(e);
            else pq1.push_back(e);
        end
    endtask

    // One clock cycle: capture outputs, advance the requester and transmitter models, drive inputs.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        cyc++;
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("ready_in_grant", 32'(req_ready & ~grant), 32'd0);
        check("write_single", 32'(tx_write & prev_write), 32'd0);
        prev_write = tx_write;
        if (tx_write) begin
            got.push_back(tx_data);
            wr_cyc.push_back(cyc);
            if (!no_busy) begin
                if (rand_busy) begin
                    rise_dly = $urandom_range(0, 3);
                    hold_len = $urandom_range(1, 5);
                end
                busy_start = cyc + rise_dly;
                busy_end = busy_start + hold_len;
            end
        end
        if (xfer0 && pq0.size() != 0) begin
            e = pq0.pop_front();
            inpkt0 = !e[8];
        end
        if (xfer1 && pq1.size() != 0) begin
            e = pq1.pop_front();
            inpkt1 = !e[8];
        end
        tx_busy = (cyc >= busy_start) && (cyc < busy_end);
        if (pq0.size() != 0 && !(inpkt0 && gaps_en && $urandom_range(0, 3) == 0)) begin
            e = pq0[0];
            req_valid[0] = 1'b1;
            req_data[7:0] = e[7:0];
            req_last[0] = e[8];
        end else begin
            req_valid[0] = 1'b0;
        end
        if (pq1.size() != 0 && !(inpkt1 && gaps_en && $urandom_range(0, 3) == 0)) begin
            e = pq1[0];
            req_valid[1] = 1'b1;
            req_data[15:8] = e[7:0];
            req_last[1] = e[8];
        end else begin
            req_valid[1] = 1'b0;
        end
        #1;
        xfer0 = req_valid[0] && req_ready[0];
        xfer1 = req_valid[1] && req_ready[1];
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        check({tag, "_write_timeout"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic run_until_idle(input string tag, input int nbytes, input int budget);
        int k;
        k = 0;
        while ((got.size() < nbytes || grant != 2'b00 || tx_busy) && k < budget) begin
            step();
            k++;
        end
        check({tag, "_drain_timeout"}, 32'(k < budget), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
        end
    endtask

    // Packet-level round-robin: requesters with work are served in turn, a whole packet each.
    task automatic model_rr();
        logic [8:0] a[$];
        logic [8:0] b[$];
        logic [8:0] e;
        int ptr;
        int k;
        a = pq0;
        b = pq1;
        ptr = 0;
        exp_q.delete();
        while (a.size() + b.size() > 0) begin
            k = ptr;
            if (k == 0 && a.size() == 0) k = 1;
            else if (k == 1 && b.size() == 0) k = 0;
            e = 9'h000;
            while (!e[8] && ((k == 0) ? a.size() : b.size()) > 0) begin
                e = (k == 0) ? a.pop_front() : b.pop_front();
                exp_q.push_back(e[7:0]);
            end
            ptr = (k + 1) % 2;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int w;
        int b;

        // Reset state
        do_reset("init");

        // Single-byte packet: grant at +1, write at +2, grant released after busy falls
        rise_dly = 2;
        hold_len = 10;
        add_pkt(0, 1, 8'hA5, 0);
        step();
        c0 = cyc;
        check("t1_idle_grant", 32'(grant), 32'd0);
        step();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_ready", 32'(req_ready), 32'h1);
        step();
        check("t1_write", 32'(tx_write), 32'd1);
        check("t1_data", 32'(tx_data), 32'hA5);
        step();
        check("t1_write_drop", 32'(tx_write), 32'd0);
        w = c0 + 2;
        step_to(w + 12);
        check("t1_grant_held", 32'(grant), 32'h1);
        step();
        check("t1_grant_rel", 32'(grant), 32'd0);
        check("t1_err", 32'(nobusy_err), 32'd0);
        exp_q = {8'hA5};
        check_stream("t1");

        // Simultaneous requests after reset: whole packets, req0 first
        do_reset("t2");
        rise_dly = 1;
        hold_len = 3;
        add_pkt(0, 3, 8'h10, 0);
        add_pkt(1, 3, 8'h20, 0);
        run_until_idle("t2", 6, 400);
        exp_q = {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        check_stream("t2");

        // Fairness: req0 back-to-back packets with req1 pending
        do_reset("t3");
        add_pkt(0, 2, 8'h30, 0);
        add_pkt(0, 2, 8'h40, 0);
        add_pkt(1, 2, 8'h50, 0);
        run_until_idle("t3", 6, 400);
        exp_q = {8'h30, 8'h31, 8'h50, 8'h51, 8'h40, 8'h41};
        check_stream("t3");

        // Transmitter never busy: 4-cycle ACK timeout per byte, sticky error
        do_reset("t4");
        no_busy = 1;
        add_pkt(0, 3, 8'h60, 0);
        wait_writes("t4", 1, 50);
        w = cyc;
        step_to(w + 3);
        check("t4_err_before", 32'(nobusy_err), 32'd0);
        step();
        check("t4_err_after", 32'(nobusy_err), 32'd1);
        run_until_idle("t4", 3, 200);
        exp_q = {8'h60, 8'h61, 8'h62};
        check_stream("t4");
        check("t4_spacing1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd6);
        check("t4_spacing2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd6);
        check("t4_err_sticky", 32'(nobusy_err), 32'd1);
        no_busy = 0;

        // Error flag cleared only by reset; then asynchronous reset mid-packet
        do_reset("t5");
        rise_dly = 2;
        hold_len = 10;
        add_pkt(0, 3, 8'h70, 0);
        wait_writes("t5", 2, 100);
        w = cyc;
        step_to(w + 4);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_grant", 32'(grant), 32'd0);
        check("t5_async_ready", 32'(req_ready), 32'd0);
        check("t5_async_data", 32'(tx_data), 32'd0);
        check("t5_async_write", 32'(tx_write), 32'd0);
        check("t5_async_err", 32'(nobusy_err), 32'd0);
        clear_bench();
        @(negedge clk);
        rst = 1'b0;
        add_pkt(1, 1, 8'h81, 0);
        step();
        step();
        check("t5_req1_grant", 32'(grant), 32'h2);
        run_until_idle("t5", 1, 100);
        exp_q = {8'h81};
        check_stream("t5");

        // Randomized traffic against the packet-level model
        rand_busy = 1;
        gaps_en = 1;
        for (int r = 0; r < 3; r++) begin
            do_reset("rnd");
            for (int p = 0; p < $urandom_range(1, 3); p++) add_pkt(0, $urandom_range(1, 4), 8'h00, 1);
            for (int p = 0; p < $urandom_range(1, 3); p++) add_pkt(1, $urandom_range(1, 4), 8'h00, 1);
            model_rr();
            run_until_idle("rnd", exp_q.size(), 3000);
            check_stream("rnd");
            check("rnd_err", 32'(nobusy_err), 32'd0);
        end
        rand_busy = 0;
        gaps_en = 0;

`ifdef FSARB_GAP_TIMEOUT_EN
        // Owner goes silent mid-packet: grant dropped after 16 idle cycles in SEND
        do_reset("gap");
        rise_dly = 2;
        hold_len = 3;
        pq0.push_back(9'h090);
        add_pkt(1, 1, 8'h91, 0);
        wait_writes("gap", 1, 50);
        b = busy_end;
        step_to(b + 16);
        check("gap_grant_held", 32'(grant), 32'h1);
        step();
        check("gap_grant_drop", 32'(grant), 32'd0);
        run_until_idle("gap", 2, 200);
        exp_q = {8'h90, 8'h91};
        check_stream("gap");
        check("gap_abort_count", 32'(abort_count), 32'd1);
`else
        b = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
